// File: rtl/acorn_pkg.sv
// Shared definitions for the ACORN-128 initialization engine: state geometry,
// feedback tap positions, FSM encoding and the initialization message schedule.
package acorn_pkg;

   localparam int STATE_W        = 293;
   localparam int KEY_W          = 128;
   localparam int CNT_W          = 11;
   localparam int INIT_STEPS_DEF = 1792;

   // Tap positions of the six concatenated LFSRs that make up the state.
   localparam int TAP_0   = 0;
   localparam int TAP_23  = 23;
   localparam int TAP_60  = 60;
   localparam int TAP_61  = 61;
   localparam int TAP_66  = 66;
   localparam int TAP_107 = 107;
   localparam int TAP_111 = 111;
   localparam int TAP_154 = 154;
   localparam int TAP_160 = 160;
   localparam int TAP_193 = 193;
   localparam int TAP_196 = 196;
   localparam int TAP_230 = 230;
   localparam int TAP_235 = 235;
   localparam int TAP_244 = 244;
   localparam int TAP_289 = 289;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } acorn_fsm_e;

   // Step 256 is the single padding step that injects an inverted key bit.
   function automatic logic acorn_mbit(input logic [CNT_W-1:0] step,
                                       input logic [KEY_W-1:0] key,
                                       input logic [KEY_W-1:0] iv);
      logic bit_v;
      if (step < CNT_W'(128))
         bit_v = key[step[6:0]];
      else if (step < CNT_W'(256))
         bit_v = iv[step[6:0]];
      else if (step == CNT_W'(256))
         bit_v = ~key[0];
      else
         bit_v = key[step[6:0]];
      return bit_v;
   endfunction

endpackage

// File: rtl/acorn_step.sv
// One combinational ACORN-128 state-update step: LFSR feedback, keystream bit,
// nonlinear feedback, then a one-position shift with the new bit entering at 292.
module acorn_step
   import acorn_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic               mbit_i,
   input  logic               ca_i,
   input  logic               cb_i,
   output logic [STATE_W-1:0] state_o
);

   logic [STATE_W-1:0] w_s;
   logic               w_ks;
   logic               w_f;

   // The LFSR updates are ordered so each one reads its neighbour's old value.
   always_comb begin
      w_s          = state_i;
      w_s[TAP_289] = w_s[TAP_289] ^ w_s[TAP_235] ^ w_s[TAP_230];
      w_s[TAP_230] = w_s[TAP_230] ^ w_s[TAP_196] ^ w_s[TAP_193];
      w_s[TAP_193] = w_s[TAP_193] ^ w_s[TAP_160] ^ w_s[TAP_154];
      w_s[TAP_154] = w_s[TAP_154] ^ w_s[TAP_111] ^ w_s[TAP_107];
      w_s[TAP_107] = w_s[TAP_107] ^ w_s[TAP_66]  ^ w_s[TAP_61];
      w_s[TAP_61]  = w_s[TAP_61]  ^ w_s[TAP_23]  ^ w_s[TAP_0];

      w_ks = w_s[12] ^ w_s[TAP_154]
           ^ ((w_s[TAP_235] & w_s[TAP_61]) ^ (w_s[TAP_235] & w_s[TAP_193])
              ^ (w_s[TAP_61] & w_s[TAP_193]))
           ^ ((w_s[TAP_230] & w_s[TAP_111]) ^ (~w_s[TAP_230] & w_s[TAP_66]));

      w_f = w_s[TAP_0] ^ ~w_s[TAP_107]
          ^ ((w_s[TAP_244] & w_s[TAP_23]) ^ (w_s[TAP_244] & w_s[TAP_160])
             ^ (w_s[TAP_23] & w_s[TAP_160]))
          ^ (ca_i & w_s[TAP_196]) ^ (cb_i & w_ks) ^ mbit_i;

      state_o = {w_f, w_s[STATE_W-1:1]};
   end

endmodule

// File: rtl/acorn_init_engine.sv
// ACORN-128 initialization engine: latches key/IV, runs INIT_STEPS state updates
// at UNROLL steps per clock, and offers the result over a valid/ready handshake.
module acorn_init_engine
   import acorn_pkg::*;
#(
   parameter int UNROLL     = 1,
   parameter int INIT_STEPS = INIT_STEPS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [KEY_W-1:0]   key_i,
   input  logic [KEY_W-1:0]   iv_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               state_valid_o,
   input  logic               state_ready_i,
   output logic [STATE_W-1:0] state_o
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 ||
         UNROLL == 8 || UNROLL == 16 || UNROLL == 32)) begin : g_bad_unroll
      $error("acorn_init_engine: UNROLL must be 1, 2, 4, 8, 16 or 32");
   end
   if ((INIT_STEPS % 128) != 0 || INIT_STEPS < 384 || INIT_STEPS >= 2048) begin : g_bad_steps
      $error("acorn_init_engine: INIT_STEPS must be a multiple of 128 in [384, 1920]");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_STEPS - UNROLL);
   localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(UNROLL);

   acorn_fsm_e         r_fsm;
   acorn_fsm_e         w_fsm_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [STATE_W-1:0] r_state;
   logic [KEY_W-1:0]   r_key;
   logic [KEY_W-1:0]   r_iv;
   logic               w_load;
   logic               w_clear;
   logic               w_advance;

   logic [STATE_W-1:0] w_chain [UNROLL+1];
   logic               w_mbit  [UNROLL];

   assign w_chain[0] = r_state;

   for (genvar k = 0; k < UNROLL; k++) begin : g_step
      assign w_mbit[k] = acorn_mbit(r_cnt + CNT_W'(k), r_key, r_iv);

      acorn_step u_step (
         .state_i (w_chain[k]),
         .mbit_i  (w_mbit[k]),
         .ca_i    (1'b1),
         .cb_i    (1'b1),
         .state_o (w_chain[k+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_fsm <= ST_IDLE;
      else
         r_fsm <= w_fsm_next;
   end

   // Abort wins over completion; in DONE a start only counts alongside ready.
   always_comb begin
      w_fsm_next = r_fsm;
      w_load     = 1'b0;
      w_clear    = 1'b0;
      w_advance  = 1'b0;
      case (r_fsm)
         ST_IDLE: begin
            if (start_i) begin
               w_fsm_next = ST_RUN;
               w_load     = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               w_fsm_next = ST_IDLE;
               w_clear    = 1'b1;
            end else begin
               w_advance = 1'b1;
               if (r_cnt == LAST_CNT)
                  w_fsm_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (state_ready_i) begin
               if (start_i) begin
                  w_fsm_next = ST_RUN;
                  w_load     = 1'b1;
               end else begin
                  w_fsm_next = ST_IDLE;
               end
            end
         end
         default: w_fsm_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_state <= '0;
         r_key   <= '0;
         r_iv    <= '0;
      end else if (w_load) begin
         r_cnt   <= '0;
         r_state <= '0;
         r_key   <= key_i;
         r_iv    <= iv_i;
      end else if (w_clear) begin
         r_cnt   <= '0;
         r_state <= '0;
      end else if (w_advance) begin
         r_cnt   <= r_cnt + CNT_INC;
         r_state <= w_chain[UNROLL];
      end
   end

   assign busy_o        = (r_fsm == ST_RUN);
   assign state_valid_o = (r_fsm == ST_DONE);
   assign state_o       = r_state;

endmodule
